// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational lookup, write commit on the request handshake,
// 64-bit cycle/instret counters, trap entry and mret restore.
module csr_file #(
   parameter logic [31:0] HART_ID     = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [11:0] req_a,
   input  logic [31:0] req_d,
   input  logic [1:0]  req_t,
   output logic        resp_exists,
   output logic [31:0] resp_d,
   input  logic        retire,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret_valid,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        mie_o
);

   logic        mstatus_mie_r;
   logic        mstatus_mpie_r;
   logic [31:0] mie_r;
   logic [31:0] mtvec_r;
   logic [31:0] mscratch_r;
   logic [31:0] mepc_r;
   logic [31:0] mcause_r;
   logic [31:0] mtval_r;
   logic [63:0] mcycle_r;
   logic [63:0] minstret_r;

   logic [63:0] mcycle_nxt_s;
   logic [63:0] minstret_nxt_s;
   logic [31:0] mstatus_s;
   logic [31:0] wdata_s;
   logic        we_s;

   // Traps and mret own the trap CSRs this cycle, so requests are stalled.
   assign req_ready = !trap_valid && !mret_valid;
   assign we_s      = req_valid && req_ready && (req_t != 2'b00);
   // MPP is hardwired to machine mode.
   assign mstatus_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};

   assign mtvec_o = mtvec_r;
   assign mepc_o  = mepc_r;
   assign mie_o   = mstatus_mie_r;

   // Address decode and old-value lookup.
   always_comb begin
      resp_exists = 1'b1;
      resp_d      = 32'd0;
      case (req_a)
         12'h300: resp_d = mstatus_s;
         12'h301: resp_d = MISA_VAL;
         12'h304: resp_d = mie_r;
         12'h305: resp_d = mtvec_r;
         12'h340: resp_d = mscratch_r;
         12'h341: resp_d = mepc_r;
         12'h342: resp_d = mcause_r;
         12'h343: resp_d = mtval_r;
         12'h344: resp_d = 32'd0;
         12'hB00, 12'hC00: resp_d = mcycle_r[31:0];
         12'hB80, 12'hC80: resp_d = mcycle_r[63:32];
         12'hB02, 12'hC02: resp_d = minstret_r[31:0];
         12'hB82, 12'hC82: resp_d = minstret_r[63:32];
         12'hF14: resp_d = HART_ID;
         default: begin
            resp_exists = 1'b0;
            resp_d      = 32'd0;
         end
      endcase
   end

   // Write/set/clear value derived from the old value.
   always_comb begin
      case (req_t)
         2'b01:   wdata_s = req_d;
         2'b10:   wdata_s = resp_d | req_d;
         2'b11:   wdata_s = resp_d & ~req_d;
         default: wdata_s = resp_d;
      endcase
   end

   // Counter next values: increment first, then a written half overrides.
   always_comb begin
      mcycle_nxt_s   = mcycle_r + 64'd1;
      minstret_nxt_s = minstret_r + {63'd0, retire};
      case ({we_s, req_a})
         13'h1B00: mcycle_nxt_s[31:0]    = wdata_s;
         13'h1B80: mcycle_nxt_s[63:32]   = wdata_s;
         13'h1B02: minstret_nxt_s[31:0]  = wdata_s;
         13'h1B82: minstret_nxt_s[63:32] = wdata_s;
         default: begin
         end
      endcase
   end

   // CSR state register: reset, then trap, then mret, then request commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_r  <= 1'b0;
         mstatus_mpie_r <= 1'b0;
         mie_r          <= 32'd0;
         mtvec_r        <= MTVEC_RESET;
         mscratch_r     <= 32'd0;
         mepc_r         <= 32'd0;
         mcause_r       <= 32'd0;
         mtval_r        <= 32'd0;
         mcycle_r       <= 64'd0;
         minstret_r     <= 64'd0;
      end else begin
         mcycle_r   <= mcycle_nxt_s;
         minstret_r <= minstret_nxt_s;
         if (trap_valid) begin
            mepc_r         <= trap_pc & 32'hFFFF_FFFC;
            mcause_r       <= trap_cause;
            mtval_r        <= trap_tval;
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
         end else if (mret_valid) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
         end else if (we_s) begin
            case (req_a)
               12'h300: begin
                  mstatus_mie_r  <= wdata_s[3];
                  mstatus_mpie_r <= wdata_s[7];
               end
               12'h304: mie_r      <= wdata_s;
               12'h305: mtvec_r    <= wdata_s & 32'hFFFF_FFFC;
               12'h340: mscratch_r <= wdata_s;
               12'h341: mepc_r     <= wdata_s & 32'hFFFF_FFFC;
               12'h342: mcause_r   <= wdata_s;
               12'h343: mtval_r    <= wdata_s;
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage: the responder end of the CSR request/response protocol driven by the execute-stage CSR unit.
- Lookup is combinational: existence flag and old value are returned in the same cycle the address is presented. Writes commit on the request handshake.
- Also owns the cycle and instret counters, trap entry (mepc/mcause/mtval/mstatus update) and mret restore.
- Exports mtvec, mepc and the global interrupt enable to the frontend and trap logic.

Parameters:
- HART_ID, 0, value read from mhartid (0xF14).
- MISA_VAL, 32'h40000100, read-only value of misa (0x301); RV32I.
- MTVEC_RESET, 32'h80000000, reset value of mtvec.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  CSR request valid (decoupled csrfile_req).
- req_ready  out  1  request accepted this cycle.
- req_a  in  12  CSR address.
- req_d  in  32  operand: write value or set/clear mask.
- req_t  in  2  op: 01 write, 10 set, 11 clear, 00 read-only/no-op.
- resp_exists  out  1  req_a names an implemented CSR (combinational, independent of req_valid).
- resp_d  out  32  current (pre-write) value at req_a; 0 if not implemented.
- retire  in  1  one instruction retired this cycle.
- trap_valid  in  1  take trap this cycle.
- trap_pc  in  32  faulting PC.
- trap_cause  in  32  mcause value.
- trap_tval  in  32  mtval value.
- mret_valid  in  1  mret commits this cycle.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mie_o  out  1  mstatus.MIE.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: only MIE[3] and MPIE[7] writable; MPP[12:11] reads 11; all other bits read 0.
  - misa 0x301; mie 0x304; mtvec 0x305 (bits[1:0] forced 0); mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342; mtval 0x343; mip 0x344 (reads 0).
  - mcycle/mcycleh 0xB00/0xB80; minstret/minstreth 0xB02/0xB82.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 are read-only aliases.
  - mhartid 0xF14.
  - Every other address: resp_exists=0, resp_d=0.
- Handshake:
  - req_ready = !trap_valid && !mret_valid (combinational).
  - A request is accepted when req_valid && req_ready; commit happens at the next rising edge.
  - resp_d always shows the old value; it is never forwarded from the write.
- Write value:
  - t=01: new = d.
  - t=10: new = old | d.
  - t=11: new = old & ~d.
  - t=00: no write.
- Writes to nonexistent addresses, to read-only CSRs (misa, mip, 0xCxx, 0xF14) or with t=00 are silently dropped, with no state change. Illegal-access exceptions are raised by the requesting unit, not here.
- Counters:
  - mcycle is 64-bit and increments by 1 every cycle when not in reset.
  - minstret is 64-bit and increments by 1 when retire=1.
  - Both wrap 2^64-1 -> 0.
  - A write to one half in the same cycle: next = (value + increment), then the written half is replaced by the write data. The other half keeps the incremented result, including any carry out of the low half.
- Trap (trap_valid=1), taking effect at the next edge:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_tval; MPIE <= MIE; MIE <= 0.
  - trap_valid has priority over mret_valid; mret is ignored if both are asserted.
  - No CSR request commits in that cycle, since req_ready=0.
- mret (mret_valid=1 and trap_valid=0): MIE <= MPIE; MPIE <= 1.
- Reset, synchronous, wins over all other events in the same cycle:
  - mtvec = MTVEC_RESET.
  - mstatus MIE=0, MPIE=0.
  - mie, mscratch, mepc, mcause, mtval and both counters = 0.
  - req_ready follows its combinational equation; outputs reflect the reset state the cycle after rst.

Test Plan:
- Reset, then read 0x300, 0x305, 0xF14 -> resp_exists=1 with resp_d = 0x00001800, 0x80000000, HART_ID respectively; read 0x7C0 -> resp_exists=0, resp_d=0.
- Write 0x340 with d=0xDEADBEEF (t=01), then set 0x000000F0 (t=10), then clear 0x0000000F (t=11) -> successive resp_d values are 0, 0xDEADBEEF, 0xDEADBEFF; a final read returns 0xDEADBEF0.
- Write mcycle (0xB00) = 0xFFFFFFFF, then read 0xB00/0xB80 over the following cycles -> low half wraps to 0 and mcycleh increments to 1; cycle (0xC00) mirrors mcycle.
- Set mstatus.MIE=1, then pulse trap_valid with pc=0x80001006, cause=2, tval=0x13 -> req_ready=0 that cycle; afterwards mepc=0x80001004, mcause=2, mtval=0x13, MIE=0, MPIE=1, mie_o=0.
- Pulse mret_valid after the trap -> MIE=1, MPIE=1, mie_o=1; assert trap_valid and mret_valid together -> trap semantics only.
- Write 0x301 and 0xC00 with nonzero d, and assert rst in the same cycle as a mscratch write -> misa is unchanged, cycle continues counting, mscratch reads 0 after reset.
